// File: rtl/fip_32_arith_unit.sv
// Sequential Q16.16 arithmetic unit: wrapping add, restoring divide and 3x3
// determinant, sharing one multiplier and one divider under a start/done handshake.
module fip_32_arith_unit (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_op,
  input  logic signed [31:0]     i_x,
  input  logic signed [31:0]     i_y,
  input  logic [2:0][2:0][31:0]  i_array,
  output logic                   o_busy,
  output logic                   o_done,
  output logic signed [31:0]     o_result,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_DET = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]            state;
  logic [5:0]            cnt;
  logic [5:0]            last_cnt;
  logic                  accept;
  logic                  exec_last;

  logic [1:0]            op_q;
  logic signed [31:0]    x_q;
  logic signed [31:0]    y_q;
  logic [2:0][2:0][31:0] a_q;

  logic [31:0]           rem_q;
  logic [47:0]           quo_q;
  logic [31:0]           dvs_q;

  logic signed [63:0]    t1_q;
  logic signed [31:0]    minor_q;
  logic signed [63:0]    acc_q;
  logic                  det_ov_q;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic fits32(input logic signed [63:0] v);
    return (v[63:31] == {33{1'b0}}) || (v[63:31] == {33{1'b1}});
  endfunction

  assign accept    = (state == S_IDLE) && i_start;
  assign exec_last = (state == S_EXEC) && (cnt == last_cnt);
  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_FINISH);

  always_comb begin
    case (op_q)
      OP_DIV:  last_cnt = 6'd49;
      OP_DET:  last_cnt = 6'd10;
      default: last_cnt = 6'd0;
    endcase
  end

  // ---------------- ADD ----------------
  logic [31:0] add_sum;
  logic        add_ov;
  assign add_sum = x_q + y_q;
  assign add_ov  = (x_q[31] == y_q[31]) && (add_sum[31] != x_q[31]);

  // ---------------- DIV ----------------
  logic [31:0] x_mag;
  logic [31:0] y_mag;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] rem_next;
  logic        div_neg;
  logic        div_zero;
  logic [31:0] div_res;
  logic        div_ov;

  assign x_mag    = mag32(x_q);
  assign y_mag    = mag32(y_q);
  assign trial    = {rem_q, quo_q[47]};
  assign trial_ge = (trial >= {1'b0, dvs_q});
  assign rem_next = trial_ge ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
  assign div_neg  = x_q[31] ^ y_q[31];
  assign div_zero = (y_q == 32'sd0);

  // Sign and saturation are applied to the finished magnitude quotient.
  always_comb begin
    div_res = 32'd0;
    div_ov  = 1'b0;
    if (div_zero) begin
      div_res = 32'd0;
    end else if (!div_neg && (quo_q > 48'h0000_7FFF_FFFF)) begin
      div_res = 32'h7FFF_FFFF;
      div_ov  = 1'b1;
    end else if (div_neg && (quo_q > 48'h0000_8000_0000)) begin
      div_res = 32'h8000_0000;
      div_ov  = 1'b1;
    end else begin
      div_res = div_neg ? (~quo_q[31:0] + 32'd1) : quo_q[31:0];
    end
  end

  // ---------------- DET ----------------
  // Schedule per cofactor j: two minor products, then a0j * minor.
  logic signed [31:0] mul_a;
  logic signed [31:0] mul_b;
  logic signed [63:0] product;
  logic signed [63:0] scaled;
  logic signed [63:0] minor_next;

  always_comb begin
    mul_a = 32'sd0;
    mul_b = 32'sd0;
    case (cnt)
      6'd0:    begin mul_a = a_q[1][1]; mul_b = a_q[2][2]; end
      6'd1:    begin mul_a = a_q[1][2]; mul_b = a_q[2][1]; end
      6'd2:    begin mul_a = a_q[0][0]; mul_b = minor_q;   end
      6'd3:    begin mul_a = a_q[1][0]; mul_b = a_q[2][2]; end
      6'd4:    begin mul_a = a_q[1][2]; mul_b = a_q[2][0]; end
      6'd5:    begin mul_a = a_q[0][1]; mul_b = minor_q;   end
      6'd6:    begin mul_a = a_q[1][0]; mul_b = a_q[2][1]; end
      6'd7:    begin mul_a = a_q[1][1]; mul_b = a_q[2][0]; end
      6'd8:    begin mul_a = a_q[0][2]; mul_b = minor_q;   end
      default: begin mul_a = 32'sd0;    mul_b = 32'sd0;    end
    endcase
  end

  assign product    = mul_a * mul_b;
  assign scaled     = product >>> 16;
  assign minor_next = t1_q - scaled;

  // NOTE: datapath registers carry no reset; they are reloaded on every
  // accepted start and never observed before being written.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q     <= i_op;
      x_q      <= i_x;
      y_q      <= i_y;
      a_q      <= i_array;
      acc_q    <= 64'sd0;
      det_ov_q <= 1'b0;
    end else if (state == S_EXEC) begin
      case (op_q)
        OP_DIV: begin
          if (cnt == 6'd0) begin
            rem_q <= 32'd0;
            quo_q <= {x_mag, 16'd0};
            dvs_q <= y_mag;
          end else if (cnt <= 6'd48) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[46:0], trial_ge};
          end
        end
        OP_DET: begin
          case (cnt)
            6'd0, 6'd3, 6'd6: begin
              t1_q <= scaled;
              if (!fits32(scaled)) det_ov_q <= 1'b1;
            end
            6'd1, 6'd4, 6'd7: begin
              minor_q <= minor_next[31:0];
              if (!fits32(scaled) || !fits32(minor_next)) det_ov_q <= 1'b1;
            end
            6'd2, 6'd8: begin
              acc_q <= acc_q + scaled;
              if (!fits32(scaled)) det_ov_q <= 1'b1;
            end
            6'd5: begin
              acc_q <= acc_q - scaled;
              if (!fits32(scaled)) det_ov_q <= 1'b1;
            end
            6'd9: begin
              if (!fits32(acc_q)) det_ov_q <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Values presented in the done cycle.
  logic [31:0] fin_result;
  logic        fin_ov;
  logic        fin_uf;

  always_comb begin
    fin_result = 32'd0;
    fin_ov     = 1'b0;
    fin_uf     = 1'b0;
    case (op_q)
      OP_ADD: begin fin_result = add_sum;      fin_ov = add_ov;                      end
      OP_DIV: begin fin_result = div_res;      fin_ov = div_ov;  fin_uf = div_zero; end
      OP_DET: begin fin_result = acc_q[31:0];  fin_ov = det_ov_q;                    end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= 6'd0;
      o_result    <= 32'sd0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_EXEC;
            cnt   <= 6'd0;
          end
        end
        S_EXEC: begin
          if (exec_last) begin
            state       <= S_FINISH;
            o_result    <= fin_result;
            o_overflow  <= fin_ov;
            o_underflow <= fin_uf;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fip_32_arith_unit.sv
// Directed plus randomized bench for fip_32_arith_unit, checked against an
// integer-arithmetic reference model.
module tb_fip_32_arith_unit;

  typedef logic [2:0][2:0][31:0] mat_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         op = 2'b00;
  logic signed [31:0] x = 32'sd0;
  logic signed [31:0] y = 32'sd0;
  mat_t               arr = '0;
  logic               busy;
  logic               done;
  logic signed [31:0] result;
  logic               ov;
  logic               uf;

  int n_cmp = 0;
  int n_bad = 0;

  fip_32_arith_unit dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_op       (op),
    .i_x        (x),
    .i_y        (y),
    .i_array    (arr),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_overflow (ov),
    .o_underflow(uf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sc(input longint a, input longint b);
    return (a * b) >>> 16;
  endfunction

  function automatic bit fits(input longint v);
    return (v >= -(longint'(1) <<< 31)) && (v < (longint'(1) <<< 31));
  endfunction

  function automatic mat_t mat_i(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    mat_t m;
    int   v[9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = v[r*3 + c] * 65536;
    return m;
  endfunction

  // Reference: plain 64-bit integer arithmetic straight from the operation rules.
  task automatic model(input logic [1:0] mop, input logic [31:0] mx, my, input mat_t ma,
                       output logic [31:0] r, output logic mov, output logic muf,
                       output int n);
    int     ix, iy, iv;
    longint lx, ly, s, q;
    longint e[3][3];
    longint p[6];
    longint m[3];
    longint t[3];
    ix = mx; iy = my; lx = ix; ly = iy;
    r = 32'd0; mov = 1'b0; muf = 1'b0; n = 1;
    case (mop)
      2'b00: begin
        s = lx + ly;
        r = s[31:0];
        mov = !fits(s);
      end
      2'b01: begin
        n = 50;
        if (ly == 0) begin
          muf = 1'b1;
        end else begin
          q = (lx * 65536) / ly;
          if (q > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF; mov = 1'b1;
          end else if (q < -64'sd2147483648) begin
            r = 32'h8000_0000; mov = 1'b1;
          end else begin
            r = q[31:0];
          end
        end
      end
      2'b10: begin
        n = 11;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            iv = ma[i][j];
            e[i][j] = iv;
          end
        p[0] = sc(e[1][1], e[2][2]); p[1] = sc(e[1][2], e[2][1]);
        p[2] = sc(e[1][0], e[2][2]); p[3] = sc(e[1][2], e[2][0]);
        p[4] = sc(e[1][0], e[2][1]); p[5] = sc(e[1][1], e[2][0]);
        m[0] = p[0] - p[1]; m[1] = p[2] - p[3]; m[2] = p[4] - p[5];
        for (int k = 0; k < 3; k++) t[k] = sc(e[0][k], longint'(int'(m[k])));
        s = t[0] - t[1] + t[2];
        for (int k = 0; k < 6; k++) if (!fits(p[k])) mov = 1'b1;
        for (int k = 0; k < 3; k++) if (!fits(m[k]) || !fits(t[k])) mov = 1'b1;
        if (!fits(s)) mov = 1'b1;
        r = s[31:0];
      end
      default: n = 1;
    endcase
  endtask

  // Issues one operation, scrambles inputs while busy, optionally pokes a
  // second start mid-operation, and checks latency, results and the done pulse.
  task automatic do_op(input logic [1:0] dop, input logic [31:0] dx, dy, input mat_t da,
                       input string tag, input bit poke);
    logic [31:0] er;
    logic        eov, euf;
    int          en, lat, guard;
    model(dop, dx, dy, da, er, eov, euf, en);
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    start = 1'b1; op = dop; x = dx; y = dy; arr = da;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      op = 2'($urandom); x = $urandom; y = $urandom;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) arr[r][c] = $urandom;
      start = poke && (lat == 2);
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, lat, en);
    check({tag, "_res"}, result, er);
    check({tag, "_ov"}, ov, eov);
    check({tag, "_uf"}, uf, euf);
    check({tag, "_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_hold"}, result, er);
  endtask

  initial begin
    mat_t m0;
    int   dones;
    logic [1:0]  rop;
    logic [31:0] rx, ry;
    mat_t        rm;

    m0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", result, 32'd0);
    check("rst_ov", ov, 1'b0);
    check("rst_uf", uf, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    do_op(2'b00, 32'h0001_0000, 32'h0001_0000, m0, "add_1p1", 1'b0);
    do_op(2'b00, 32'h7FFF_FFFF, 32'h0001_0000, m0, "add_ovf", 1'b0);
    do_op(2'b00, 32'hFFFF_0000, 32'hFFFF_FFFF, m0, "add_neg", 1'b0);
    do_op(2'b11, 32'h1234_5678, 32'h1111_1111, m0, "reserved", 1'b0);

    do_op(2'b01, 32'h0002_0000, 32'h0002_0000, m0, "div_1", 1'b0);
    do_op(2'b01, 32'h0000_8000, 32'h0000_4000, m0, "div_2", 1'b0);
    do_op(2'b01, 32'h0000_0002, 32'h0000_0003, m0, "div_2_3", 1'b0);
    do_op(2'b01, 32'hFFFF_0000, 32'h0000_8000, m0, "div_neg", 1'b0);
    do_op(2'b01, 32'h0001_0000, 32'h0000_0000, m0, "div_zero", 1'b0);
    do_op(2'b01, 32'h8000_0000, 32'h0000_8000, m0, "div_satn", 1'b0);
    do_op(2'b01, 32'h7FFF_FFFF, 32'h0000_4000, m0, "div_satp", 1'b0);

    do_op(2'b10, 32'd0, 32'd0, mat_i(1, 0, 0, 0, 1, 0, 0, 0, 1), "det_id", 1'b0);
    do_op(2'b10, 32'd0, 32'd0, mat_i(1, 2, 3, 4, 5, 6, 7, 8, 9), "det_sing", 1'b0);
    do_op(2'b10, 32'd0, 32'd0, mat_i(1, -1, 3, 4, 5, 6, 7, 8, 9), "det_m18", 1'b0);
    do_op(2'b10, 32'd0, 32'd0, {9{32'h7FFF_0000}}, "det_ovf", 1'b0);
    do_op(2'b10, 32'd0, 32'd0, mat_i(2, 0, 1, 1, 3, 2, 1, 1, 1), "det_poke", 1'b1);
    do_op(2'b01, 32'h7FFF_FFFF, 32'h0000_4000, m0, "div_pre_rst", 1'b0);

    // Reset in the middle of a divide: outputs clear and no done follows.
    @(negedge clk);
    start = 1'b1; op = 2'b01; x = 32'h0003_0000; y = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_res", result, 32'd0);
    check("midrst_ov", ov, 1'b0);
    check("midrst_uf", uf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (60) begin @(posedge clk); #1; if (done) dones++; end
    check("midrst_nodone", dones, 0);
    do_op(2'b01, 32'h0003_0000, 32'h0001_0000, m0, "div_after_rst", 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ry = -ry;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          rm[r][c] = $urandom_range(0, 32'h0080_0000) - 32'h0040_0000;
      do_op(rop, rx, ry, rm, $sformatf("rnd%0d_op%0d", i, rop), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
